fc_layer_engine: RTL
====================

# fc_layer_engine

Multi-output fully-connected layer engine, the parametrised successor to the single-output pointwise 1x1 engine used for FC layers. It computes `num_outputs` dot products of length `num_inputs` back-to-back, with no reset or clear between output channels. Each result gets a bias, rounding requantisation and optional ReLU. It sits between the weight/activation streamer and the feature-map buffer in the inference datapath.

## Interface
- `NUM_MACS`, 16, number of parallel lanes per beat
- `ACT_W`, 8, activation width (unsigned)
- `WT_W`, 8, weight width (signed)
- `ACC_W`, 32, accumulator and bias width (signed)
- `MAX_IN`, 1024, maximum `num_inputs`; sets the counter width
- `MAX_OUT`, 256, maximum `num_outputs`; sets the index width

Ports:
- `clock` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-high
- `num_inputs` in $clog2(MAX_IN+1): dot-product length; sampled on `start`
- `num_outputs` in $clog2(MAX_OUT+1): output channel count; sampled on `start`
- `shift` in 5: requant right shift (0..31); sampled on `start`
- `relu_en` in 1: 1 selects clamp [0,255], 0 selects clamp [-128,127]; sampled on `start`
- `start` in 1: one-cycle pulse, accepted only in IDLE
- `in_valid` in 1: beat valid
- `in_ready` out 1: beat accepted when `in_valid && in_ready`
- `activations` in NUM_MACS x ACT_W: lane activations
- `weights` in NUM_MACS x WT_W: lane weights
- `bias` in ACC_W: bias for the current channel; sampled with the channel's first beat, or at REQUANT entry when `num_inputs`=0
- `out_valid` out 1: result valid
- `out_ready` in 1: result consumed when `out_valid && out_ready`
- `out_data` out 8: requantised result
- `out_index` out $clog2(MAX_OUT): channel index of `out_data`
- `busy` out 1: high in any state other than IDLE
- `done` out 1: one-cycle pulse after the last result handshake

## Operation
States: IDLE, ACCUM, REQUANT, OUTPUT, DONE.
- **IDLE:** on `start`, latch the config and clear the accumulator, input counter and channel index.
  - If `num_outputs`=0, go to DONE.
  - Else if `num_inputs`=0, go to REQUANT.
  - Else go to ACCUM.
- **ACCUM:** `in_ready`=1.
  - Each accepted beat adds the sum over valid lanes of `act * wt` to the accumulator. Activations are zero-extended and weights sign-extended.
  - Lanes with index >= `num_inputs - consumed` are masked to 0 (tail beat).
  - The first beat of a channel loads `bias + beat_sum` into the accumulator, overwriting it. No clear input is needed.
  - Accepting the beat that reaches `num_inputs` moves to REQUANT.
- **REQUANT:** lasts one cycle.
  - `y = (acc + rnd) >>> shift`, where `rnd = 1<<(shift-1)` if `shift`>0, else 0. Full-width arithmetic shift.
  - `y` is clamped per `relu_en`, registered into `out_data` and `out_index`, and `out_valid` is set.
- **OUTPUT:** hold `out_valid`, `out_data` and `out_index` stable until `out_ready`.
  - On handshake, increment the index.
  - If the index equals `num_outputs`, go to DONE.
  - Else clear the input counter and go to ACCUM, or to REQUANT when `num_inputs`=0.
- **DONE:** `done`=1 for one cycle, then IDLE.
- **Arithmetic:** the accumulator wraps two's-complement at ACC_W. ACC_W is sized so that MAX_IN products cannot overflow.

## Timing
- **Reset values:** `in_ready`, `out_valid`, `busy`, `done` = 0; `out_data`, `out_index` = 0; state IDLE.
- **Latency:** the edge accepting a channel's last beat enters REQUANT. `out_valid` is high after the next edge (1 cycle later).
- **Throughput:** ceil(`num_inputs`/NUM_MACS) + 2 cycles minimum per channel when `out_ready`=1.
- **Handshakes:** `in_ready` depends only on state, never on `in_valid`. `in_ready`=0 whenever `out_valid`=1.
- **start while busy:** ignored.
- **Config inputs:** changes after `start` have no effect until the next `start`.
- **Reset mid-operation:** return to IDLE in the next cycle, drop all outputs to reset values, and discard any partial accumulation. No `done` pulse.
- **num_inputs=0:** each output is requant(bias).
- **num_outputs=0:** `done` pulses 2 cycles after `start`, with no `out_valid`.

## Structure
- **Package `fc_pkg`:**
  - state enum `fc_state_t`
  - default width constants
  - function `fc_requant(acc, shift, relu_en)` returning 8 bits, shared with the reference model
- **Sub-module `fc_mac_lane_tree`:** NUM_MACS signed multipliers, a lane mask input, and a combinational adder tree producing an ACC_W beat sum.
- The top level holds the FSM, counters, accumulator and output register.

## Test plan
- **Basic dot product:** `num_inputs`=512, `num_outputs`=1, `act[i]`=i+1, `wt`=1, `bias`=0, `shift`=5, `relu_en`=1 -> acc 4352, `out_data`=136, `out_index`=0, then a `done` pulse.
- **Back-to-back channels:** same stimulus with `num_outputs`=64 and no reset between channels -> 64 results of 136 with indices 0..63 in order, exactly one `done` pulse. With `shift`=0, every result saturates to 255.
- **Tail masking:** `num_inputs`=20, all lanes act=1, wt=1, lanes 4..15 of the 2nd beat carrying act=0x7F, wt=0x7F -> `out_data`=20.
- **Sign and clamp:** 16 inputs, act=10, wt=-1 (acc -160).
  - `relu_en`=1 -> 0.
  - `relu_en`=0 -> 0x80 (-128).
- **Bias only:** `num_inputs`=0, `bias`=300, `shift`=1, `relu_en`=1 -> (301>>1)=150.
- **Backpressure and reset:**
  - Hold `out_ready`=0 for 10 cycles -> `out_valid` and `out_data` stay stable and `in_ready`=0.
  - Assert `reset` mid-ACCUM -> `busy`=0 after the next edge.
  - A fresh `start` then yields the correct result (136).

Source files
------------

// File: rtl/fc_pkg.sv
// Shared types, default widths and requantisation for the FC layer engine.
// Contents: fc_state_t FSM encoding, FC_* default parameters, fc_requant().
// fc_requant() is the single definition of rounding, shifting and clamping.
package fc_pkg;

    localparam int FC_NUM_MACS = 16;
    localparam int FC_ACT_W    = 8;
    localparam int FC_WT_W     = 8;
    localparam int FC_ACC_W    = 32;
    localparam int FC_MAX_IN   = 1024;
    localparam int FC_MAX_OUT  = 256;

    typedef enum logic [2:0] {
        FC_IDLE,
        FC_ACCUM,
        FC_REQUANT,
        FC_OUTPUT,
        FC_DONE
    } fc_state_t;

    // Round-half-up arithmetic right shift at accumulator width, then clamp
    // to [0,255] (ReLU) or [-128,127] (signed int8).
    function automatic logic [7:0] fc_requant(
        input logic signed [FC_ACC_W-1:0] acc,
        input logic        [4:0]          shift,
        input logic                       relu_en
    );
        logic signed [FC_ACC_W-1:0] rnd;
        logic signed [FC_ACC_W-1:0] y;
        logic        [7:0]          res;
        rnd = '0;
        if (shift != 5'd0) begin
            rnd = FC_ACC_W'(1) << (shift - 5'd1);
        end
        y = (acc + rnd) >>> shift;
        if (relu_en) begin
            if (y < 0)        res = 8'h00;
            else if (y > 255) res = 8'hFF;
            else              res = y[7:0];
        end else begin
            if (y < -128)     res = 8'h80;
            else if (y > 127) res = 8'h7F;
            else              res = y[7:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/fc_mac_lane_tree.sv
// Purpose: NUM_MACS unsigned-act x signed-wt products, lane-masked, summed to ACC_W.
// Latency: purely combinational. Backpressure: none, caller qualifies the result.
// Ports: act_i/wt_i lane operands, lane_mask_i lane enables, beat_sum_o signed sum.
module fc_mac_lane_tree
    import fc_pkg::*;
#(
    parameter int NUM_MACS = FC_NUM_MACS,
    parameter int ACT_W    = FC_ACT_W,
    parameter int WT_W     = FC_WT_W,
    parameter int ACC_W    = FC_ACC_W
) (
    input  logic [NUM_MACS-1:0][ACT_W-1:0] act_i,
    input  logic [NUM_MACS-1:0][WT_W-1:0]  wt_i,
    input  logic [NUM_MACS-1:0]            lane_mask_i,
    output logic signed [ACC_W-1:0]        beat_sum_o
);

    // An unsigned ACT_W times signed WT_W product always fits in ACT_W+WT_W bits.
    localparam int PROD_W = ACT_W + WT_W;

    logic signed [PROD_W-1:0] prod [NUM_MACS];

    always_comb begin
        beat_sum_o = '0;
        for (int i = 0; i < NUM_MACS; i++) begin
            // Zero-extend the activation so it stays non-negative once signed.
            prod[i] = PROD_W'($signed({1'b0, act_i[i]})) * PROD_W'($signed(wt_i[i]));
            if (!lane_mask_i[i]) begin
                prod[i] = '0;
            end
            beat_sum_o = beat_sum_o + ACC_W'(prod[i]);
        end
    end

endmodule

// File: rtl/fc_layer_engine.sv
// Purpose: num_outputs back-to-back dot products with bias, rounding requant and optional ReLU.
// Latency: result valid one edge after the edge accepting a channel's last beat.
// Backpressure: in_ready only in ACCUM; out_valid/out_data/out_index held until out_ready.
// Ports: clock/reset (sync, active-high); config num_inputs/num_outputs/shift/relu_en
// sampled on start; in_valid/in_ready beats of activations/weights plus per-channel bias;
// out_valid/out_ready result with out_data/out_index; busy (not IDLE); done one-cycle pulse.
module fc_layer_engine
    import fc_pkg::*;
#(
    parameter int NUM_MACS = FC_NUM_MACS,
    parameter int ACT_W    = FC_ACT_W,
    parameter int WT_W     = FC_WT_W,
    parameter int ACC_W    = FC_ACC_W,
    parameter int MAX_IN   = FC_MAX_IN,
    parameter int MAX_OUT  = FC_MAX_OUT
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [$clog2(MAX_IN+1)-1:0]       num_inputs,
    input  logic [$clog2(MAX_OUT+1)-1:0]      num_outputs,
    input  logic [4:0]                        shift,
    input  logic                              relu_en,
    input  logic                              start,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [NUM_MACS-1:0][ACT_W-1:0]    activations,
    input  logic [NUM_MACS-1:0][WT_W-1:0]     weights,
    input  logic signed [ACC_W-1:0]           bias,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [7:0]                        out_data,
    output logic [$clog2(MAX_OUT)-1:0]        out_index,
    output logic                              busy,
    output logic                              done
);

    localparam int CNT_W  = $clog2(MAX_IN + 1);
    localparam int OCNT_W = $clog2(MAX_OUT + 1);
    localparam int IDX_W  = $clog2(MAX_OUT);

    fc_state_t                state_q;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;        // inputs consumed in this channel
    logic [OCNT_W-1:0]        idx_q, idx_d;        // channel index, wide enough to reach num_outputs
    logic [CNT_W-1:0]         num_in_q;
    logic [OCNT_W-1:0]        num_out_q;
    logic [4:0]               shift_q;
    logic                     relu_q;
    logic                     out_valid_q;
    logic [7:0]               out_data_q;
    logic [IDX_W-1:0]         out_index_q;
    logic                     done_q;

    logic [CNT_W-1:0]         remaining;
    logic                     last_beat;
    logic [NUM_MACS-1:0]      lane_mask;
    logic signed [ACC_W-1:0]  beat_sum;

    fc_mac_lane_tree #(
        .NUM_MACS (NUM_MACS),
        .ACT_W    (ACT_W),
        .WT_W     (WT_W),
        .ACC_W    (ACC_W)
    ) u_lanes (
        .act_i       (activations),
        .wt_i        (weights),
        .lane_mask_i (lane_mask),
        .beat_sum_o  (beat_sum)
    );

    always_comb begin
        remaining = num_in_q - cnt_q;
        last_beat = (remaining <= CNT_W'(NUM_MACS));
        for (int i = 0; i < NUM_MACS; i++) begin
            lane_mask[i] = (remaining > CNT_W'(i));
        end
        cnt_d = last_beat ? num_in_q : cnt_q + CNT_W'(NUM_MACS);
        // The first beat of every channel overwrites the accumulator with
        // bias + sum, so consecutive channels need no explicit clear.
        acc_d = (cnt_q == '0) ? bias + beat_sum : acc_q + beat_sum;
        idx_d = idx_q + OCNT_W'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= FC_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            num_in_q    <= '0;
            num_out_q   <= '0;
            shift_q     <= '0;
            relu_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_index_q <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                FC_IDLE: begin
                    if (start) begin
                        num_in_q  <= num_inputs;
                        num_out_q <= num_outputs;
                        shift_q   <= shift;
                        relu_q    <= relu_en;
                        acc_q     <= '0;
                        cnt_q     <= '0;
                        idx_q     <= '0;
                        if (num_outputs == '0) begin
                            state_q <= FC_DONE;
                        end else if (num_inputs == '0) begin
                            acc_q   <= bias;   // bias-only channel
                            state_q <= FC_REQUANT;
                        end else begin
                            state_q <= FC_ACCUM;
                        end
                    end
                end
                FC_ACCUM: begin
                    if (in_valid) begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_d;
                        if (last_beat) begin
                            state_q <= FC_REQUANT;
                        end
                    end
                end
                FC_REQUANT: begin
                    out_data_q  <= fc_requant(acc_q, shift_q, relu_q);
                    out_index_q <= idx_q[IDX_W-1:0];
                    out_valid_q <= 1'b1;
                    state_q     <= FC_OUTPUT;
                end
                FC_OUTPUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        idx_q       <= idx_d;
                        cnt_q       <= '0;
                        if (idx_d == num_out_q) begin
                            state_q <= FC_DONE;
                        end else if (num_in_q == '0) begin
                            acc_q   <= bias;
                            state_q <= FC_REQUANT;
                        end else begin
                            state_q <= FC_ACCUM;
                        end
                    end
                end
                FC_DONE: begin
                    done_q  <= 1'b1;
                    state_q <= FC_IDLE;
                end
                default: state_q <= FC_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == FC_ACCUM);
    assign busy      = (state_q != FC_IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_index = out_index_q;
    assign done      = done_q;

endmodule
